cpu_insn_packer: RTL and testbench
==================================

# cpu_insn_packer

Producer side of the fetch-to-decode instruction interface. It accepts the raw 16-bit halfword stream from instruction fetch and buffers it in a small FIFO. It then assembles complete moxie instructions (a 16-bit opcode, plus a 32-bit operand for long forms) and presents each one as a single registered beat on `opcode_o`/`operand_o`/`valid_o` to `cpu_decode`. It sits between the fetch unit and the decode stage.

## Interface
- `DEPTH`, default 4: halfword FIFO depth; power of two, ≥2.
- `clk_i` in 1: clock; all state updates on rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `hw_i` in 16: instruction halfword from fetch, in program order.
- `hw_valid_i` in 1: `hw_i` is valid.
- `hw_ready_o` out 1: FIFO can accept; a push occurs when `hw_valid_i && hw_ready_o`.
- `flush_i` in 1: synchronous discard of all buffered and partial state (branch/exception redirect).
- `stall_i` in 1: decode cannot take a new beat; the current output is held.
- `opcode_o` out 16: assembled opcode.
- `operand_o` out 32: assembled operand; 0 for 16-bit instructions.
- `valid_o` out 1: `opcode_o`/`operand_o` form a complete instruction.

## Operation
- **Length rule.** The instruction is long (opcode + 2 operand halfwords) when `opcode[15:8]` is one of: 0x01, 0x03, 0x08, 0x09, 0x0C, 0x0D, 0x1A, 0x1B, 0x1D, 0x1F, 0x20, 0x22, 0x24, 0x30, 0x36, 0x37, 0x38, 0x39. Every other opcode, including all with bit15=1 (form 2/3), is short.
- **Operand order.** The first operand halfword is `operand_o[31:16]` and the second is `operand_o[15:0]`.
- **FIFO.** `hw_ready_o = !full && !flush_i`. A full FIFO refuses a push even if a pop occurs in the same cycle. Pop is gated by `!empty`. A push and a pop in the same cycle are allowed when the FIFO is neither full nor empty.
- **Output slot.** The slot is free when `!valid_o || !stall_i`.
- **FSM states:**
  - **S_OPC:** if the FIFO is non-empty and the slot is free, pop and latch the opcode.
    - Short opcode: load the output (`operand_o`=0), set `valid_o`=1, stay in S_OPC.
    - Long opcode: hold the opcode internally and go to S_OPH. If the slot is free and no new beat is loaded, clear `valid_o`.
  - **S_OPH:** if the FIFO is non-empty, pop into `operand[31:16]` and go to S_OPL. This pop does not depend on `stall_i`.
  - **S_OPL:** if the FIFO is non-empty and the slot is free, pop into `operand[15:0]`, load the output with `valid_o`=1, and go to S_OPC.
- **Beat consumption.** A beat is consumed on any edge where `valid_o && !stall_i`. If no new beat is loaded on that edge, `valid_o` goes to 0.
- **Flush.** `flush_i` has highest priority over everything except reset. On the edge where it is sampled:
  - the FIFO empties;
  - the FSM goes to S_OPC;
  - `valid_o` goes to 0;
  - partial opcode/operand state is discarded;
  - no push or pop takes effect.
  - `opcode_o`/`operand_o` may retain stale values.

## Timing
- **Reset values:** `valid_o`=0, `opcode_o`=0, `operand_o`=0, FSM=S_OPC, FIFO empty, so `hw_ready_o`=1 (while `flush_i`=0). Reset mid-instruction discards all partial state immediately.
- **No bypass.** A halfword pushed at edge N is poppable at edge N+1.
- **Short instruction:** pushed at edge N gives `valid_o`=1 after edge N+1.
- **Long instruction:** halfwords pushed at edges N, N+1, N+2 give `valid_o` after edge N+3.
- **Sustained rate:** one short instruction per cycle; one long instruction per 3 cycles.
- **Stall:** while `stall_i`=1 with `valid_o`=1, the outputs are bit-stable. The FIFO keeps filling until `hw_ready_o` drops at DEPTH entries. S_OPH pops may still proceed.
- **Outputs:** all outputs are registered except `hw_ready_o`, which is combinational from the FIFO count and `flush_i`.
- **FIFO pointers:** `$clog2(DEPTH)` bits, wrapping modulo DEPTH. The count is `$clog2(DEPTH)+1` bits.

## Structure
- **Package `cpu_pkg`** holds:
  - the opcode-byte constants for the long forms listed above;
  - function `insn_is_long(opcode[15:0])`;
  - FSM state enum `S_OPC`/`S_OPH`/`S_OPL`.
- **Sub-module `cpu_hw_fifo`** (parameter DEPTH, 16-bit data): push/pop/flush inputs; full/empty/count outputs. It is shared with future fetch buffering.

## Test plan
- **Short form 1:** push 0x0523 at edge N → `valid_o`=1 after N+1; `opcode_o`=0x0523, `operand_o`=0x00000000; `valid_o`=0 after N+2.
- **Long:** push 0x0120, 0xDEAD, 0xBEEF back-to-back → one beat after N+3 with `opcode_o`=0x0120 and `operand_o`=0xDEADBEEF; no intermediate beats.
- **Mixed stream under stall:**
  - Stimulus: push 0x8105, 0xC00A, 0x1A00, 0x0000, 0x1000 with `stall_i`=1 from the first beat.
  - Required: `hw_ready_o`=0 at 4 entries; `opcode_o`=0x8105 is held stable.
  - Release `stall_i`: required beats are 0x8105, then 0xC00A, then jmpa 0x1A00 with operand 0x00001000, in order.
- **Flush mid-operand:** accept 0x1A00 and 0x1234, assert `flush_i` for 1 cycle, then push 0x9203 → `valid_o` stays 0 through the flush; the next beat is `opcode_o`=0x9203 with operand 0 (stale halfwords are never emitted).
- **Async reset:** assert `rst_i` mid-cycle while in S_OPL with 2 FIFO entries → `valid_o`=0 and `hw_ready_o`=1 immediately, without waiting for a clock edge; the next pushed 0x0400 emits as a short beat.
- **FIFO wrap:** stream 64 randomly chosen short/long instructions with random `hw_valid_i`/`stall_i` gaps, so the pointers wrap many times → the output sequence matches a reference model exactly, with no beat while `stall_i` drops data and no FIFO overflow.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-to-decode instruction packer.
package cpu_pkg;

    localparam int unsigned HW_W   = 16;
    localparam int unsigned OPND_W = 32;

    // Opcode bytes of the long forms (opcode followed by a 32-bit operand).
    localparam logic [7:0] OPB_LDI_L = 8'h01;
    localparam logic [7:0] OPB_JSRA  = 8'h03;
    localparam logic [7:0] OPB_LDA_L = 8'h08;
    localparam logic [7:0] OPB_STA_L = 8'h09;
    localparam logic [7:0] OPB_LDO_L = 8'h0C;
    localparam logic [7:0] OPB_STO_L = 8'h0D;
    localparam logic [7:0] OPB_JMPA  = 8'h1A;
    localparam logic [7:0] OPB_LDI_B = 8'h1B;
    localparam logic [7:0] OPB_LDA_B = 8'h1D;
    localparam logic [7:0] OPB_STA_B = 8'h1F;
    localparam logic [7:0] OPB_LDI_S = 8'h20;
    localparam logic [7:0] OPB_LDA_S = 8'h22;
    localparam logic [7:0] OPB_STA_S = 8'h24;
    localparam logic [7:0] OPB_SWI   = 8'h30;
    localparam logic [7:0] OPB_LDO_B = 8'h36;
    localparam logic [7:0] OPB_STO_B = 8'h37;
    localparam logic [7:0] OPB_LDO_S = 8'h38;
    localparam logic [7:0] OPB_STO_S = 8'h39;

    typedef enum logic [1:0] {
        S_OPC = 2'd0,
        S_OPH = 2'd1,
        S_OPL = 2'd2
    } insn_state_e;

    // True when the opcode carries two trailing operand halfwords.
    function automatic logic insn_is_long(input logic [15:0] opcode);
        logic r;
        case (opcode[15:8])
            OPB_LDI_L, OPB_JSRA,  OPB_LDA_L, OPB_STA_L, OPB_LDO_L, OPB_STO_L,
            OPB_JMPA,  OPB_LDI_B, OPB_LDA_B, OPB_STA_B, OPB_LDI_S, OPB_LDA_S,
            OPB_STA_S, OPB_SWI,   OPB_LDO_B, OPB_STO_B, OPB_LDO_S, OPB_STO_S:
                r = 1'b1;
            default:
                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_hw_fifo.sv
// Halfword FIFO with synchronous flush; push refused when full, pop when empty.
module cpu_hw_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [15:0]                data_i,
    output logic [15:0]                data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [15:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign data_o  = r_mem[r_rd_ptr];

    // Flush wins over both push and pop.
    assign w_push = push_i && !full_o && !flush_i;
    assign w_pop  = pop_i && !empty_o && !flush_i;

    // Storage array, written on accepted pushes.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_insn_packer.sv
// Assembles fetched halfwords into complete moxie instructions for decode.
module cpu_insn_packer
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] hw_i,
    input  logic        hw_valid_i,
    output logic        hw_ready_o,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic [15:0] opcode_o,
    output logic [31:0] operand_o,
    output logic        valid_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    insn_state_e       r_state;
    insn_state_e       w_state_d;
    logic [HW_W-1:0]   r_opc_hold;
    logic [HW_W-1:0]   w_opc_hold_d;
    logic [HW_W-1:0]   r_opnd_hi;
    logic [HW_W-1:0]   w_opnd_hi_d;
    logic [HW_W-1:0]   r_opcode;
    logic [HW_W-1:0]   w_opcode_d;
    logic [OPND_W-1:0] r_operand;
    logic [OPND_W-1:0] w_operand_d;
    logic              r_valid;
    logic              w_valid_d;

    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [HW_W-1:0]   w_head;
    logic              w_has_data;
    logic              w_slot_free;

    assign hw_ready_o  = !w_full && !flush_i;
    assign w_push      = hw_valid_i && hw_ready_o;
    assign w_has_data  = !w_empty && (w_count != '0);
    assign w_slot_free = !r_valid || !stall_i;

    assign opcode_o  = r_opcode;
    assign operand_o = r_operand;
    assign valid_o   = r_valid;

    cpu_hw_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (hw_i),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_OPC;
            r_opc_hold <= '0;
            r_opnd_hi  <= '0;
            r_opcode   <= '0;
            r_operand  <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_opc_hold <= w_opc_hold_d;
            r_opnd_hi  <= w_opnd_hi_d;
            r_opcode   <= w_opcode_d;
            r_operand  <= w_operand_d;
            r_valid    <= w_valid_d;
        end
    end

    // Next-state, FIFO pop and output beat assembly.
    always_comb begin
        w_state_d    = r_state;
        w_opc_hold_d = r_opc_hold;
        w_opnd_hi_d  = r_opnd_hi;
        w_opcode_d   = r_opcode;
        w_operand_d  = r_operand;
        w_valid_d    = r_valid && stall_i;  // a beat taken by decode retires
        w_pop        = 1'b0;

        if (flush_i) begin
            w_state_d    = S_OPC;
            w_valid_d    = 1'b0;
            w_opc_hold_d = '0;
            w_opnd_hi_d  = '0;
        end else begin
            case (r_state)
                S_OPC: begin
                    if (w_has_data && w_slot_free) begin
                        w_pop = 1'b1;
                        if (insn_is_long(w_head)) begin
                            w_opc_hold_d = w_head;
                            w_state_d    = S_OPH;
                        end else begin
                            w_opcode_d  = w_head;
                            w_operand_d = '0;
                            w_valid_d   = 1'b1;
                        end
                    end
                end
                S_OPH: begin
                    // Operand high half never touches the output slot.
                    if (w_has_data) begin
                        w_pop       = 1'b1;
                        w_opnd_hi_d = w_head;
                        w_state_d   = S_OPL;
                    end
                end
                S_OPL: begin
                    if (w_has_data && w_slot_free) begin
                        w_pop       = 1'b1;
                        w_opcode_d  = r_opc_hold;
                        w_operand_d = {r_opnd_hi, w_head};
                        w_valid_d   = 1'b1;
                        w_state_d   = S_OPC;
                    end
                end
                default: begin
                    w_state_d = S_OPC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_insn_packer.sv
// Scoreboard bench for cpu_insn_packer.
module tb_cpu_insn_packer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] hw_i;
    logic        hw_valid_i;
    logic        hw_ready_o;
    logic        flush_i;
    logic        stall_i;
    logic [15:0] opcode_o;
    logic [31:0] operand_o;
    logic        valid_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [47:0] exp_q[$];
    int          m_phase = 0;
    logic [15:0] m_opc;
    logic [15:0] m_hi;
    bit          rnd_done = 1'b0;

    cpu_insn_packer #(.DEPTH(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .hw_i       (hw_i),
        .hw_valid_i (hw_valid_i),
        .hw_ready_o (hw_ready_o),
        .flush_i    (flush_i),
        .stall_i    (stall_i),
        .opcode_o   (opcode_o),
        .operand_o  (operand_o),
        .valid_o    (valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit tb_is_long(input logic [7:0] b);
        case (b)
            8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
            8'h1F, 8'h20, 8'h22, 8'h24, 8'h30, 8'h36, 8'h37, 8'h38, 8'h39: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference model fed by accepted halfwords; checks each beat as decode sees it.
    task automatic monitor();
        logic [47:0] e;
        forever begin
            @(negedge clk_i);
            if (rst_i || flush_i) begin
                exp_q.delete();
                m_phase = 0;
            end else begin
                if (valid_o) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", {48'h0, opcode_o}, 64'h0);
                    end else begin
                        e = exp_q[0];
                        check("beat_opcode", 64'(opcode_o), 64'(e[47:32]));
                        check("beat_operand", 64'(operand_o), 64'(e[31:0]));
                        if (!stall_i) void'(exp_q.pop_front());
                    end
                end
                if (hw_valid_i && hw_ready_o) begin
                    case (m_phase)
                        0: begin
                            if (tb_is_long(hw_i[15:8])) begin
                                m_opc = hw_i;
                                m_phase = 1;
                            end else begin
                                exp_q.push_back({hw_i, 32'h0});
                            end
                        end
                        1: begin
                            m_hi = hw_i;
                            m_phase = 2;
                        end
                        default: begin
                            exp_q.push_back({m_opc, m_hi, hw_i});
                            m_phase = 0;
                        end
                    endcase
                end
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_hw(input logic [15:0] hw);
        int budget = 0;
        bit ok;
        hw_i = hw;
        hw_valid_i = 1'b1;
        do begin
            @(negedge clk_i);
            ok = hw_ready_o;
            @(posedge clk_i);
            #1;
            budget++;
        end while (!ok && budget < 200);
        hw_valid_i = 1'b0;
        if (!ok) check("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_drain(input string tag);
        int budget = 0;
        while ((exp_q.size() != 0 || valid_o) && budget < 300) begin
            step(1);
            budget++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [7:0] long_tab [18];
        logic [15:0] op;
        long_tab = '{8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
                     8'h1F, 8'h20, 8'h22, 8'h24, 8'h30, 8'h36, 8'h37, 8'h38, 8'h39};
        rst_i = 1'b1; hw_i = '0; hw_valid_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        fork monitor(); join_none
        step(2);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_opcode", 64'(opcode_o), 64'd0);
        check("rst_operand", 64'(operand_o), 64'd0);
        check("rst_ready", 64'(hw_ready_o), 64'd1);
        rst_i = 1'b0;
        step(1);

        // Short form.
        push_hw(16'h0523);
        check("short_pre", 64'(valid_o), 64'd0);
        step(1);
        check("short_valid", 64'(valid_o), 64'd1);
        check("short_opcode", 64'(opcode_o), 64'h0523);
        check("short_operand", 64'(operand_o), 64'h0);
        step(1);
        check("short_retire", 64'(valid_o), 64'd0);

        // Long form.
        push_hw(16'h0120);
        push_hw(16'hDEAD);
        push_hw(16'hBEEF);
        check("long_pre", 64'(valid_o), 64'd0);
        step(1);
        check("long_valid", 64'(valid_o), 64'd1);
        check("long_opcode", 64'(opcode_o), 64'h0120);
        check("long_operand", 64'(operand_o), 64'hDEADBEEF);
        wait_drain("long_drain");

        // Mixed stream under stall.
        stall_i = 1'b1;
        push_hw(16'h8105);
        push_hw(16'hC00A);
        push_hw(16'h1A00);
        push_hw(16'h0000);
        push_hw(16'h1000);
        check("stall_ready", 64'(hw_ready_o), 64'd0);
        check("stall_opcode", 64'(opcode_o), 64'h8105);
        check("stall_valid", 64'(valid_o), 64'd1);
        step(3);
        check("stall_hold", 64'(opcode_o), 64'h8105);
        stall_i = 1'b0;
        wait_drain("mixed_drain");

        // Flush mid-operand.
        push_hw(16'h1A00);
        push_hw(16'h1234);
        flush_i = 1'b1;
        #1;
        check("flush_ready", 64'(hw_ready_o), 64'd0);
        check("flush_valid_in", 64'(valid_o), 64'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("flush_valid_out", 64'(valid_o), 64'd0);
        push_hw(16'h9203);
        step(1);
        check("post_flush_opcode", 64'(opcode_o), 64'h9203);
        check("post_flush_operand", 64'(operand_o), 64'h0);
        wait_drain("flush_drain");

        // Async reset while in S_OPL with two entries buffered.
        stall_i = 1'b1;
        push_hw(16'h0523);
        push_hw(16'h0120);
        push_hw(16'h1111);
        push_hw(16'h2222);
        push_hw(16'h3333);
        stall_i = 1'b0;
        step(2);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_valid", 64'(valid_o), 64'd0);
        check("arst_ready", 64'(hw_ready_o), 64'd1);
        check("arst_opcode", 64'(opcode_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        push_hw(16'h0400);
        step(1);
        check("arst_next_opcode", 64'(opcode_o), 64'h0400);
        check("arst_next_operand", 64'(operand_o), 64'h0);
        wait_drain("arst_drain");

        // Random stream: pointer wrap with stall/valid gaps.
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        op = {long_tab[$urandom_range(0, 17)], 8'($urandom)};
                        repeat ($urandom_range(0, 2)) step(1);
                        push_hw(op);
                        push_hw(16'($urandom));
                        repeat ($urandom_range(0, 1)) step(1);
                        push_hw(16'($urandom));
                    end else begin
                        op = 16'($urandom);
                        while (tb_is_long(op[15:8])) op = 16'($urandom);
                        repeat ($urandom_range(0, 2)) step(1);
                        push_hw(op);
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk_i);
                    #1;
                    stall_i = ($urandom_range(0, 2) == 0);
                end
                stall_i = 1'b0;
            end
        join
        stall_i = 1'b0;
        wait_drain("random_drain");
        check("random_model_idle", 64'(m_phase), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
